// File: rtl/tone_seq_gen.sv
// tone_seq_gen: divisor-table square-wave tone generator with a programmable beat tick
// and a beat-counted note sequencer. Define STACCATO_EN to silence the last beat of every note.
module tone_seq_gen #(
    parameter int                         NUM_NOTES      = 8,
    parameter int                         CNT_W          = 18,
    parameter logic [NUM_NOTES*CNT_W-1:0] NOTE_DIV_TABLE = {18'd95555, 18'd101239, 18'd113635,
                                                            18'd127550, 18'd143171, 18'd151684,
                                                            18'd170264, 18'd191109},
    parameter int                         BEAT_W         = 28,
    parameter logic [BEAT_W-1:0]          BEAT_DIV_RST   = 28'd49_999_999,
    parameter int                         DUR_W          = 4
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         NOTE_VALID,
    output logic                         NOTE_READY,
    input  logic [$clog2(NUM_NOTES)-1:0] NOTE_SEL,
    input  logic [1:0]                   OCTAVE,
    input  logic [DUR_W-1:0]             NOTE_DUR,
    input  logic                         ABORT,
    input  logic                         TEMPO_LOAD,
    input  logic [BEAT_W-1:0]            BEAT_DIV,
    output logic                         TONE,
    output logic                         TONE_ACTIVE,
    output logic                         BEAT_TICK,
    output logic                         NOTE_DONE,
    output logic [1:0]                   dbg_state
);

    localparam int SEL_W = $clog2(NUM_NOTES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
`ifdef STACCATO_EN
    localparam logic [1:0] S_GAP  = 2'd2;
`endif

    logic [1:0]        state;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] beat_per;
    logic [CNT_W-1:0]  tone_cnt;
    logic [CNT_W-1:0]  half;
    logic [DUR_W-1:0]  rem;
    logic              rest;

    logic [CNT_W-1:0]  sel_div;
    logic              sel_hit;
    logic [CNT_W:0]    div_plus1;
    logic [CNT_W:0]    div_shift;
    logic [CNT_W-1:0]  half_next;
    logic [DUR_W-1:0]  dur_next;
    logic              accept;

    // Beat generator: free-running in every state; a tempo load restarts the beat and
    // suppresses any tick that would have fallen on the same cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            beat_cnt  <= '0;
            beat_per  <= BEAT_DIV_RST;
            BEAT_TICK <= 1'b0;
        end else if (TEMPO_LOAD) begin
            beat_cnt  <= '0;
            beat_per  <= BEAT_DIV;
            BEAT_TICK <= 1'b0;
        end else if (beat_cnt == beat_per) begin
            beat_cnt  <= '0;
            BEAT_TICK <= 1'b1;
        end else begin
            beat_cnt  <= beat_cnt + BEAT_W'(1);
            BEAT_TICK <= 1'b0;
        end
    end

    // Out-of-range selects fall through with sel_hit low and play as a rest.
    always_comb begin
        sel_div = '0;
        sel_hit = 1'b0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (NOTE_SEL == SEL_W'(i)) begin
                sel_div = NOTE_DIV_TABLE[i*CNT_W +: CNT_W];
                sel_hit = 1'b1;
            end
        end
    end

    assign div_plus1 = {1'b0, sel_div} + (CNT_W+1)'(1);
    assign div_shift = div_plus1 >> OCTAVE;
    assign half_next = (div_shift == '0) ? '0 : CNT_W'(div_shift - (CNT_W+1)'(1));
    assign dur_next  = (NOTE_DUR == '0) ? DUR_W'(1) : NOTE_DUR;

    // Handshake: NOTE_READY is high only in IDLE; a request transfers on any cycle with
    // NOTE_VALID & NOTE_READY & ~ABORT, and the note inputs are captured on that edge.
    assign accept = (state == S_IDLE) & NOTE_VALID & ~ABORT;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            TONE      <= 1'b0;
            NOTE_DONE <= 1'b0;
            tone_cnt  <= '0;
            half      <= '0;
            rem       <= '0;
            rest      <= 1'b0;
        end else begin
            NOTE_DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    TONE <= 1'b0;
                    if (accept) begin
                        half     <= half_next;
                        rest     <= ~sel_hit;
                        rem      <= dur_next;
                        tone_cnt <= '0;
`ifdef STACCATO_EN
                        state    <= (dur_next == DUR_W'(1)) ? S_GAP : S_PLAY;
`else
                        state    <= S_PLAY;
`endif
                    end
                end
                S_PLAY: begin
                    if (ABORT) begin
                        state <= S_IDLE;
                        TONE  <= 1'b0;
                    end else if (BEAT_TICK && rem == DUR_W'(1)) begin
                        state     <= S_IDLE;
                        TONE      <= 1'b0;
                        NOTE_DONE <= 1'b1;
                    end else begin
                        if (tone_cnt == half) begin
                            tone_cnt <= '0;
                            TONE     <= ~TONE & ~rest;
                        end else begin
                            tone_cnt <= tone_cnt + CNT_W'(1);
                        end
                        if (BEAT_TICK) begin
                            rem <= rem - DUR_W'(1);
`ifdef STACCATO_EN
                            // Last beat is silent: leave PLAY as soon as one beat remains.
                            if (rem == DUR_W'(2)) begin
                                state <= S_GAP;
                                TONE  <= 1'b0;
                            end
`endif
                        end
                    end
                end
`ifdef STACCATO_EN
                S_GAP: begin
                    TONE <= 1'b0;
                    if (ABORT) begin
                        state <= S_IDLE;
                    end else if (BEAT_TICK) begin
                        rem       <= rem - DUR_W'(1);
                        state     <= S_IDLE;
                        NOTE_DONE <= 1'b1;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                    TONE  <= 1'b0;
                end
            endcase
        end
    end

    assign NOTE_READY  = (state == S_IDLE);
    assign TONE_ACTIVE = (state != S_IDLE);
    assign dbg_state   = state;

endmodule
